// File: rtl/div_seq_param.sv
// -----------------------------------------------------------------------------
// div_seq_param
//   Sequential radix-2 restoring divider, WIDTH bits (legal 4..64). It takes
//   WIDTH+1 cycles per operation and 1 cycle for divide-by-zero. Signed or
//   unsigned mode is chosen for each operation.
//
//   Ports
//     clk_i           rising-edge clock
//     rst_ni          asynchronous active-low reset
//     start_i         request, sampled only while idle
//     signed_mode_i   1 = two's-complement operands, captured with start_i
//     dividend_i      dividend, captured with start_i
//     divisor_i       divisor, captured with start_i
//     busy_o          operation in progress
//     done_o          one-cycle pulse, results valid
//     quotient_o      quotient, held until the next done
//     remainder_o     remainder, held until the next done
//     div_by_zero_o   divisor was zero, held with the results
// -----------------------------------------------------------------------------
module div_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  // Control state (reset)
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbzo_q, dbzo_d;

  // Datapath (no reset; always loaded on capture before use)
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude; quotient bits shift in at LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;    // divisor magnitude
  logic [WIDTH:0]   prem_q, prem_d;  // partial remainder, one guard bit

  logic                accept;
  logic                div_zero_in;
  logic [WIDTH:0]      shifted;
  logic signed [WIDTH:0] diff;
  logic                qbit;

  // Absolute value in signed mode. The most negative value maps onto its own
  // bit pattern. Read as unsigned, that pattern is the correct magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sm);
    return (sm && v[WIDTH-1]) ? (-v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (-v) : v;
  endfunction

  assign accept      = (state_q == S_IDLE) && start_i;
  assign div_zero_in = (divisor_i == '0);

  // One restoring step. prem_q < dvs_q always holds, so shifted < 2*dvs_q
  // fits in WIDTH+1 bits, and the sign of diff decides the quotient bit.
  always_comb begin
    shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff    = signed'(shifted) - signed'({1'b0, dvs_q});
    qbit    = ~diff[WIDTH];
  end

  // Control next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbzo_d  = dbzo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = div_zero_in ? S_FIX : S_CALC;
          cnt_d   = '0;
          qneg_d  = signed_mode_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          rneg_d  = signed_mode_i & dividend_i[WIDTH-1];
          dbz_d   = div_zero_in;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dbz_q) begin
          // dvd_q holds the raw dividend on this path
          quo_d  = '1;
          rem_d  = dvd_q;
          dbzo_d = 1'b1;
        end else begin
          quo_d  = cond_neg(dvd_q, qneg_q);
          rem_d  = cond_neg(prem_q[WIDTH-1:0], rneg_q);
          dbzo_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    if (accept) begin
      dvd_d  = div_zero_in ? dividend_i : mag(dividend_i, signed_mode_i);
      dvs_d  = mag(divisor_i, signed_mode_i);
      prem_d = '0;
    end else if (state_q == S_CALC) begin
      dvd_d  = {dvd_q[WIDTH-2:0], qbit};
      prem_d = qbit ? unsigned'(diff) : shifted;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbzo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbzo_q  <= dbzo_d;
    end
  end

  always_ff @(posedge clk_i) begin
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    prem_q <= prem_d;
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbzo_q;

endmodule

// File: tb/tb_div_seq_param.sv
`timescale 1ns/1ps
module tb_div_seq_param;

  logic        clk;
  logic        rst_n;

  logic        s32_start, s32_sm, s32_busy, s32_done, s32_dz;
  logic [31:0] s32_a, s32_b, s32_q, s32_r;
  logic        s8_start, s8_sm, s8_busy, s8_done, s8_dz;
  logic [7:0]  s8_a, s8_b, s8_q, s8_r;

  int n_chk;
  int n_fail;

  logic [31:0] pq [2];
  logic [31:0] pr [2];
  logic        pdz [2];

  div_seq_param #(.WIDTH(32)) u32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s32_start), .signed_mode_i(s32_sm),
    .dividend_i(s32_a), .divisor_i(s32_b), .busy_o(s32_busy), .done_o(s32_done),
    .quotient_o(s32_q), .remainder_o(s32_r), .div_by_zero_o(s32_dz)
  );

  div_seq_param #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s8_start), .signed_mode_i(s8_sm),
    .dividend_i(s8_a), .divisor_i(s8_b), .busy_o(s8_busy), .done_o(s8_done),
    .quotient_o(s8_q), .remainder_o(s8_r), .div_by_zero_o(s8_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer division on sign-extended or zero-extended values.
  function automatic void ref_div(input int w, input bit sm, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output bit dz);
    longint unsigned mask;
    longint sa, sb, qq, rr;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a) & longint'(mask);
    sb = longint'(b) & longint'(mask);
    if (sb == 0) begin
      q  = mask[31:0];
      r  = sa[31:0];
      dz = 1'b1;
    end else begin
      if (sm) begin
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
      end
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0] & mask[31:0];
      r  = rr[31:0] & mask[31:0];
      dz = 1'b0;
    end
  endfunction

  task automatic drive(input bit w8, input bit st, input bit sm,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      s8_start = st; s8_sm = sm; s8_a = a[7:0]; s8_b = b[7:0];
    end else begin
      s32_start = st; s32_sm = sm; s32_a = a; s32_b = b;
    end
  endtask

  function automatic logic [31:0] get_q(input bit w8);
    return w8 ? {24'd0, s8_q} : s32_q;
  endfunction
  function automatic logic [31:0] get_r(input bit w8);
    return w8 ? {24'd0, s8_r} : s32_r;
  endfunction
  function automatic logic get_dz(input bit w8);
    return w8 ? s8_dz : s32_dz;
  endfunction
  function automatic logic get_busy(input bit w8);
    return w8 ? s8_busy : s32_busy;
  endfunction
  function automatic logic get_done(input bit w8);
    return w8 ? s8_done : s32_done;
  endfunction

  // Issue one operation and wait for done. Checks that the previous results
  // hold across the accept, that done is a single pulse, and that results stay stable.
  task automatic run_op(input bit w8, input bit sm, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb,
                        output logic [31:0] q, output logic [31:0] r,
                        output bit dz, output int lat, output int bcnt);
    int idx;
    idx = w8 ? 1 : 0;
    @(negedge clk);
    drive(w8, 1'b1, sm, a, b);
    @(posedge clk); #1;
    drive(w8, 1'b0, ~sm, ~a, b ^ 32'h3C);
    chk("hold_q_at_accept", get_q(w8), pq[idx]);
    chk("hold_r_at_accept", get_r(w8), pr[idx]);
    chk("hold_dz_at_accept", get_dz(w8), pdz[idx]);
    bcnt = get_busy(w8) ? 1 : 0;
    lat = 0;
    while (lat < 100) begin
      if (disturb && lat == 4) drive(w8, 1'b1, ~sm, a ^ 32'h5A, b + 32'd1);
      if (disturb && lat == 5) drive(w8, 1'b0, sm, a, b);
      @(posedge clk); #1;
      lat++;
      if (get_busy(w8)) bcnt++;
      if (get_done(w8)) break;
    end
    if (lat >= 100) chk("done_timeout", get_done(w8), 1'b1);
    q  = get_q(w8);
    r  = get_r(w8);
    dz = get_dz(w8);
    @(posedge clk); #1;
    chk("done_single_pulse", get_done(w8), 1'b0);
    chk("q_stable_after_done", get_q(w8), q);
    chk("r_stable_after_done", get_r(w8), r);
    pq[idx]  = q;
    pr[idx]  = r;
    pdz[idx] = dz;
  endtask

  typedef struct {
    bit          w8;
    bit          sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic reset_checks(input string tag);
    chk({tag, "_busy32"}, s32_busy, 1'b0);
    chk({tag, "_done32"}, s32_done, 1'b0);
    chk({tag, "_q32"}, s32_q, 32'd0);
    chk({tag, "_r32"}, s32_r, 32'd0);
    chk({tag, "_dz32"}, s32_dz, 1'b0);
    chk({tag, "_busy8"}, s8_busy, 1'b0);
    chk({tag, "_q8"}, s8_q, 8'd0);
    chk({tag, "_r8"}, s8_r, 8'd0);
    chk({tag, "_dz8"}, s8_dz, 1'b0);
  endtask

  initial begin
    logic [31:0] q, r, eq, er, a, b;
    bit          dz, edz, sm, w8;
    int          lat, bc, e, last, dcount, pick;
    logic [31:0] bb_a [3];
    logic [31:0] bb_b [3];

    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 2; i++) begin pq[i] = 0; pr[i] = 0; pdz[i] = 0; end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    vecs.push_back('{0, 0, 32'd6971645, 32'd5739, 32'd1214, 32'd4499, 0, 33});
    vecs.push_back('{0, 0, 32'd49267485, 32'd15384, 32'd3202, 32'd7917, 0, 33});
    vecs.push_back('{1, 1, 32'hF9, 32'h02, 32'hFD, 32'hFF, 0, 9});
    vecs.push_back('{1, 1, 32'h07, 32'hFE, 32'hFD, 32'h01, 0, 9});
    vecs.push_back('{1, 1, 32'h80, 32'hFF, 32'h80, 32'h00, 0, 9});
    vecs.push_back('{1, 0, 32'hC8, 32'h07, 32'h1C, 32'h04, 0, 9});
    vecs.push_back('{1, 1, 32'hC8, 32'h07, 32'hF8, 32'h00, 0, 9});
    vecs.push_back('{1, 0, 32'h55, 32'h00, 32'hFF, 32'h55, 1, 1});
    vecs.push_back('{0, 0, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1, 1});
    vecs.push_back('{0, 1, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1, 1});
    vecs.push_back('{0, 0, 32'd6971645, 32'd5739, 32'd1214, 32'd4499, 0, 33});

    foreach (vecs[i]) begin
      run_op(vecs[i].w8, vecs[i].sm, vecs[i].a, vecs[i].b, 1'b0, q, r, dz, lat, bc);
      chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      chk($sformatf("vec%0d_div_by_zero", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].lat);
    end

    // start pulsed mid-CALC with other operands must be ignored
    run_op(1'b0, 1'b0, 32'd6971645, 32'd5739, 1'b1, q, r, dz, lat, bc);
    chk("midcalc_start_q", q, 32'd1214);
    chk("midcalc_start_r", r, 32'd4499);
    chk("midcalc_start_lat", lat, 33);
    @(posedge clk); #1;
    chk("midcalc_no_extra_op", s32_busy, 1'b0);

    // start held high: new accept the edge after each done
    bb_a[0] = 32'd6971645;  bb_b[0] = 32'd5739;
    bb_a[1] = 32'd49267485; bb_b[1] = 32'd15384;
    bb_a[2] = 32'd1000;     bb_b[2] = 32'd3;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, bb_a[0], bb_b[0]);
    e = 0; last = 0; dcount = 0;
    while (dcount < 3 && e < 300) begin
      @(posedge clk); #1;
      e++;
      if (s32_done) begin
        ref_div(32, 1'b0, bb_a[dcount], bb_b[dcount], eq, er, edz);
        chk($sformatf("b2b%0d_q", dcount), s32_q, eq);
        chk($sformatf("b2b%0d_r", dcount), s32_r, er);
        chk($sformatf("b2b%0d_busy_low_at_done", dcount), s32_busy, 1'b0);
        if (dcount == 0) chk("b2b_first_latency", e - 1, 33);
        else chk($sformatf("b2b%0d_period", dcount), e - last, 34);
        last = e;
        pq[0] = eq; pr[0] = er; pdz[0] = edz;
        dcount++;
        if (dcount < 3) drive(1'b0, 1'b1, 1'b0, bb_a[dcount], bb_b[dcount]);
        else drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    chk("b2b_done_count", dcount, 3);
    @(posedge clk); #1;
    chk("b2b_stopped", s32_busy, 1'b0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd6971645, 32'd5739);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #2;
    chk("pre_reset_busy", s32_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_checks("async_reset");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no_done_in_reset", s32_done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin pq[i] = 0; pr[i] = 0; pdz[i] = 0; end
    run_op(1'b0, 1'b0, 32'd6971645, 32'd5739, 1'b0, q, r, dz, lat, bc);
    chk("post_reset_q", q, 32'd1214);
    chk("post_reset_r", r, 32'd4499);
    chk("post_reset_lat", lat, 33);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      w8   = (i % 2) == 1;
      sm   = $urandom_range(0, 1) == 1;
      a    = $urandom;
      b    = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) b = 32'd0;
      else if (pick == 1) b = 32'hFFFFFFFF;
      else if (pick == 2) b = $urandom_range(1, 15);
      if (pick == 1 && $urandom_range(0, 1) == 1) a = w8 ? 32'h80 : 32'h80000000;
      if (w8 && $urandom_range(0, 1) == 1) b = b & 32'h0F;
      ref_div(w8 ? 8 : 32, sm, a, b, eq, er, edz);
      run_op(w8, sm, a, b, 1'b0, q, r, dz, lat, bc);
      chk($sformatf("rand%0d_q(a=%0h b=%0h sm=%0d w8=%0d)", i, a, b, sm, w8), q, eq);
      chk($sformatf("rand%0d_r", i), r, er);
      chk($sformatf("rand%0d_dz", i), dz, edz);
      chk($sformatf("rand%0d_lat", i), lat, edz ? 1 : (w8 ? 9 : 33));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
